// File: rtl/word_lock_pkg.sv
// Shared constants for the sync-header word-lock state machine.
package word_lock_pkg;

   localparam int unsigned CNT_W = 8;
   localparam int unsigned ERR_W = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_HUNT   = 2'd0;
   localparam state_t ST_SLIP   = 2'd1;
   localparam state_t ST_GRACE  = 2'd2;
   localparam state_t ST_LOCKED = 2'd3;

endpackage

// File: rtl/sat_cntr.sv
// Saturating up-counter with synchronous reset, clear and increment enable.
module sat_cntr #(
   parameter int TARGET_CHIP = 2,
   parameter int WIDTH       = 16
) (
   input  logic             clk,
   input  logic             sclr,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_inc_val;
   logic             w_full;

   // Both forms detect all-ones; family 0 prefers a wide compare over a carry chain.
   if (TARGET_CHIP == 0) begin : g_cmp
      assign w_full    = (r_count == '1);
      assign w_inc_val = r_count + WIDTH'(1);
   end else begin : g_carry
      logic [WIDTH:0] w_sum;
      assign w_sum     = {1'b0, r_count} + {{WIDTH{1'b0}}, 1'b1};
      assign w_full    = w_sum[WIDTH];
      assign w_inc_val = w_sum[WIDTH-1:0];
   end

   always_comb begin
      w_next = r_count;
      if (clear)
         w_next = '0;
      else if (inc && !w_full)
         w_next = w_inc_val;
   end

   always_ff @(posedge clk) begin
      if (sclr)
         r_count <= '0;
      else
         r_count <= w_next;
   end

   assign count = r_count;

endmodule

// File: rtl/word_lock_fsm.sv
// Block-lock state machine: hunts for a run of good sync headers, slips on errors,
// and monitors the bad-header rate per window once locked.
module word_lock_fsm
   import word_lock_pkg::*;
#(
   parameter int TARGET_CHIP   = 2,
   parameter int GOOD_TO_LOCK  = 64,
   parameter int BAD_TO_UNLOCK = 16,
   parameter int WINDOW        = 64
) (
   input  logic              clk,
   input  logic              sclr,
   input  logic              hdr_valid,
   input  logic              hdr_good,
   input  logic              grace,
   output logic              start_grace,
   output logic              slip,
   output logic              word_locked,
   output logic              lock_lost,
   output logic [ERR_W-1:0]  err_cnt
);

   localparam logic [CNT_W-1:0] L_GOOD = CNT_W'(GOOD_TO_LOCK);
   localparam logic [CNT_W-1:0] L_BAD  = CNT_W'(BAD_TO_UNLOCK);
   localparam logic [CNT_W-1:0] L_WIN  = CNT_W'(WINDOW);

   state_t           r_state;
   logic [CNT_W-1:0] r_good_cnt;
   logic [CNT_W-1:0] r_win_cnt;
   logic [CNT_W-1:0] r_bad_cnt;
   logic             r_dwell;
   logic             r_slip;
   logic             r_start_grace;
   logic             r_word_locked;
   logic             r_lock_lost;

   logic             w_hdr_ok;
   logic             w_hdr_bad;
   logic [CNT_W-1:0] w_good_nxt;
   logic [CNT_W-1:0] w_win_nxt;
   logic [CNT_W-1:0] w_bad_nxt;
   logic             w_err_inc;

   assign w_hdr_ok   = hdr_valid & hdr_good;
   assign w_hdr_bad  = hdr_valid & ~hdr_good;
   assign w_good_nxt = r_good_cnt + CNT_W'(1);
   assign w_win_nxt  = r_win_cnt + CNT_W'(1);
   assign w_bad_nxt  = r_bad_cnt + CNT_W'(w_hdr_bad);
   assign w_err_inc  = (r_state == ST_LOCKED) & w_hdr_bad;

   // Thresholds are tested on the incremented value so the header that crosses
   // one acts on the same edge, keeping input-to-output latency at one cycle.
   always_ff @(posedge clk) begin
      if (sclr) begin
         r_state       <= ST_HUNT;
         r_good_cnt    <= '0;
         r_win_cnt     <= '0;
         r_bad_cnt     <= '0;
         r_dwell       <= 1'b0;
         r_slip        <= 1'b0;
         r_start_grace <= 1'b0;
         r_word_locked <= 1'b0;
         r_lock_lost   <= 1'b0;
      end else begin
         r_slip        <= 1'b0;
         r_start_grace <= 1'b0;
         r_lock_lost   <= 1'b0;
         case (r_state)
            ST_HUNT: begin
               if (w_hdr_bad) begin
                  r_good_cnt    <= '0;
                  r_state       <= ST_SLIP;
                  r_slip        <= 1'b1;
                  r_start_grace <= 1'b1;
               end else if (w_hdr_ok) begin
                  if (w_good_nxt == L_GOOD) begin
                     r_good_cnt    <= '0;
                     r_win_cnt     <= '0;
                     r_bad_cnt     <= '0;
                     r_state       <= ST_LOCKED;
                     r_word_locked <= 1'b1;
                  end else begin
                     r_good_cnt <= w_good_nxt;
                  end
               end
            end
            ST_SLIP: begin
               r_state <= ST_GRACE;
               r_dwell <= 1'b0;
            end
            ST_GRACE: begin
               if (r_dwell && !grace) begin
                  r_state    <= ST_HUNT;
                  r_good_cnt <= '0;
               end else begin
                  r_dwell <= 1'b1;
               end
            end
            ST_LOCKED: begin
               if (hdr_valid) begin
                  // Unlock is checked first so it wins over a coincident window end.
                  if (w_bad_nxt == L_BAD) begin
                     r_state       <= ST_SLIP;
                     r_slip        <= 1'b1;
                     r_start_grace <= 1'b1;
                     r_lock_lost   <= 1'b1;
                     r_word_locked <= 1'b0;
                     r_win_cnt     <= '0;
                     r_bad_cnt     <= '0;
                  end else if (w_win_nxt == L_WIN) begin
                     r_win_cnt <= '0;
                     r_bad_cnt <= '0;
                  end else begin
                     r_win_cnt <= w_win_nxt;
                     r_bad_cnt <= w_bad_nxt;
                  end
               end
            end
            default: begin
               r_state       <= ST_HUNT;
               r_word_locked <= 1'b0;
            end
         endcase
      end
   end

   sat_cntr #(
      .TARGET_CHIP (TARGET_CHIP),
      .WIDTH       (ERR_W)
   ) u_err_cnt (
      .clk   (clk),
      .sclr  (sclr),
      .clear (1'b0),
      .inc   (w_err_inc),
      .count (err_cnt)
   );

   assign slip        = r_slip;
   assign start_grace = r_start_grace;
   assign word_locked = r_word_locked;
   assign lock_lost   = r_lock_lost;

endmodule

// File: tb/tb_word_lock_fsm.sv
// Bench for word_lock_fsm: directed scenarios plus random traffic against a header-count model.
module tb_word_lock_fsm;

   localparam int G2L = 64;
   localparam int B2U = 16;
   localparam int WIN = 64;

   logic        clk = 1'b0;
   logic        sclr = 1'b1;
   logic        hdr_valid = 1'b0;
   logic        hdr_good = 1'b0;
   logic        grace = 1'b0;
   logic        start_grace;
   logic        slip;
   logic        word_locked;
   logic        lock_lost;
   logic [15:0] err_cnt;

   int n_vec = 0;
   int n_bad = 0;

   // model: lock flag, pulses, grace age (-1 = not waiting on the timer), header counts
   bit m_locked = 0;
   bit m_slip = 0;
   bit m_lost = 0;
   bit m_prev = 0;
   int m_age = -1;
   int m_good = 0;
   int m_win = 0;
   int m_bad = 0;
   int m_err = 0;

   always #5 clk = ~clk;

   word_lock_fsm #(
      .TARGET_CHIP   (2),
      .GOOD_TO_LOCK  (G2L),
      .BAD_TO_UNLOCK (B2U),
      .WINDOW        (WIN)
   ) dut (
      .clk         (clk),
      .sclr        (sclr),
      .hdr_valid   (hdr_valid),
      .hdr_good    (hdr_good),
      .grace       (grace),
      .start_grace (start_grace),
      .slip        (slip),
      .word_locked (word_locked),
      .lock_lost   (lock_lost),
      .err_cnt     (err_cnt)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (sclr) begin
         m_locked = 0; m_slip = 0; m_lost = 0; m_age = -1;
         m_good = 0; m_win = 0; m_bad = 0; m_err = 0;
      end else begin
         m_prev = m_slip;
         m_slip = 0;
         m_lost = 0;
         if (m_prev) begin
            m_age = 0;
         end else if (m_age >= 0) begin
            if (m_age >= 1 && !grace) begin
               m_age = -1;
               m_good = 0;
            end else begin
               m_age++;
            end
         end else if (m_locked) begin
            if (hdr_valid) begin
               m_win++;
               if (!hdr_good) begin
                  m_bad++;
                  if (m_err < 65535) m_err++;
               end
               if (m_bad == B2U) begin
                  m_locked = 0; m_lost = 1; m_slip = 1; m_win = 0; m_bad = 0;
               end else if (m_win == WIN) begin
                  m_win = 0; m_bad = 0;
               end
            end
         end else if (hdr_valid) begin
            if (hdr_good) begin
               m_good++;
               if (m_good == G2L) begin
                  m_locked = 1; m_good = 0; m_win = 0; m_bad = 0;
               end
            end else begin
               m_good = 0;
               m_slip = 1;
            end
         end
      end
      #1;
      chk("slip", {15'd0, slip}, {15'd0, m_slip});
      chk("start_grace", {15'd0, start_grace}, {15'd0, m_slip});
      chk("word_locked", {15'd0, word_locked}, {15'd0, m_locked});
      chk("lock_lost", {15'd0, lock_lost}, {15'd0, m_lost});
      chk("err_cnt", err_cnt, 16'(m_err));
   end

   task automatic step(input logic v, input logic g, input logic gr);
      @(negedge clk);
      sclr = 1'b0; hdr_valid = v; hdr_good = g; grace = gr;
   endtask

   task automatic sclr_pulse();
      @(negedge clk);
      sclr = 1'b1; hdr_valid = 1'b1; hdr_good = 1'b0; grace = 1'b1;
   endtask

   task automatic goods(input int n, input logic gr);
      repeat (n) step(1'b1, 1'b1, gr);
   endtask

   task automatic bads(input int n);
      repeat (n) step(1'b1, 1'b0, 1'b0);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_slip"}, {15'd0, slip}, 16'd0);
      chk({name, "_sg"}, {15'd0, start_grace}, 16'd0);
      chk({name, "_locked"}, {15'd0, word_locked}, 16'd0);
      chk({name, "_lost"}, {15'd0, lock_lost}, 16'd0);
      chk({name, "_err"}, err_cnt, 16'd0);
   endtask

   initial begin
      int pb[4] = '{1, 4, 20, 35};
      int pbad;

      repeat (3) sclr_pulse();
      after_edge();
      chk_all_zero("reset");

      // first lock: 64th good header
      goods(63, 1'b0);
      after_edge(); chk("hunt63", {15'd0, word_locked}, 16'd0);
      step(1'b1, 1'b1, 1'b0);
      after_edge(); chk("lock64", {15'd0, word_locked}, 16'd1);
      chk("lock64_slip", {15'd0, slip}, 16'd0);

      // two windows with 15 bad each stay locked
      repeat (2) begin
         bads(15);
         goods(49, 1'b0);
      end
      after_edge(); chk("win15_locked", {15'd0, word_locked}, 16'd1);
      chk("win15_err", err_cnt, 16'd30);
      bads(15);
      after_edge(); chk("bad15_locked", {15'd0, word_locked}, 16'd1);
      bads(1);
      after_edge();
      chk("bad16_lost", {15'd0, lock_lost}, 16'd1);
      chk("bad16_slip", {15'd0, slip}, 16'd1);
      chk("bad16_sg", {15'd0, start_grace}, 16'd1);
      chk("bad16_locked", {15'd0, word_locked}, 16'd0);
      chk("bad16_err", err_cnt, 16'd46);
      step(1'b0, 1'b0, 1'b1);
      after_edge(); chk("slip_1cyc", {15'd0, slip}, 16'd0);
      chk("lost_1cyc", {15'd0, lock_lost}, 16'd0);
      repeat (8) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      step(1'b0, 1'b0, 1'b0);

      // hunt: 10 good then a bad; grace high 8 cycles
      goods(10, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      after_edge(); chk("hunt_bad_slip", {15'd0, slip}, 16'd1);
      chk("hunt_bad_sg", {15'd0, start_grace}, 16'd1);
      chk("hunt_bad_err", err_cnt, 16'd46);
      step(1'b1, 1'b1, 1'b1);
      after_edge(); chk("hunt_slip_end", {15'd0, slip}, 16'd0);
      repeat (7) step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
      step(1'b1, 1'b1, 1'b0);
      goods(63, 1'b0);
      after_edge(); chk("regrace63", {15'd0, word_locked}, 16'd0);
      step(1'b1, 1'b1, 1'b0);
      after_edge(); chk("regrace64", {15'd0, word_locked}, 16'd1);

      // 16th bad on the 64th window header
      goods(48, 1'b0);
      bads(15);
      after_edge(); chk("coinc63", {15'd0, word_locked}, 16'd1);
      bads(1);
      after_edge(); chk("coinc_lost", {15'd0, lock_lost}, 16'd1);
      chk("coinc_locked", {15'd0, word_locked}, 16'd0);
      chk("coinc_err", err_cnt, 16'd62);

      // grace already low: two-cycle dwell before hunting
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      goods(63, 1'b0);
      after_edge(); chk("dwell63", {15'd0, word_locked}, 16'd0);
      step(1'b1, 1'b1, 1'b0);
      after_edge(); chk("dwell64", {15'd0, word_locked}, 16'd1);

      // sclr while locked, then headers right after release
      sclr_pulse();
      after_edge(); chk_all_zero("sclr_locked");
      goods(63, 1'b0);
      after_edge(); chk("post_sclr63", {15'd0, word_locked}, 16'd0);
      step(1'b1, 1'b1, 1'b0);
      after_edge(); chk("post_sclr64", {15'd0, word_locked}, 16'd1);

      // sclr during grace; grace stays high while hunting
      bads(16);
      after_edge(); chk("unlock2", {15'd0, lock_lost}, 16'd1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      sclr_pulse();
      after_edge(); chk_all_zero("sclr_grace");
      goods(63, 1'b1);
      after_edge(); chk("grace_hunt63", {15'd0, word_locked}, 16'd0);
      step(1'b1, 1'b1, 1'b1);
      after_edge(); chk("grace_hunt64", {15'd0, word_locked}, 16'd1);

      // error counter near full
      step(1'b0, 1'b0, 1'b0);
      force dut.u_err_cnt.r_count = 16'hFFF8;
      m_err = 16'hFFF8;
      after_edge(); chk("preload", err_cnt, 16'hFFF8);
      release dut.u_err_cnt.r_count;
      bads(10);
      after_edge(); chk("sat_a", err_cnt, 16'hFFFF);
      goods(54, 1'b0);
      bads(3);
      after_edge(); chk("sat_b", err_cnt, 16'hFFFF);
      chk("sat_locked", {15'd0, word_locked}, 16'd1);

      // random traffic with varying error rates
      for (int seg = 0; seg < 8; seg++) begin
         pbad = pb[seg % 4];
         repeat (500) begin
            if ($urandom_range(0, 299) == 0)
               sclr_pulse();
            else
               step(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 99) >= pbad),
                    1'($urandom_range(0, 9) < 6));
         end
      end
      step(1'b0, 1'b0, 1'b0);
      after_edge();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
